// File: rtl/regfile_wb.sv
// regfile_wb: 64-bit ARMv8 GPR file at the end of the write-back path.
// Two combinational read ports with same-cycle write bypass. A pending-write
// scoreboard flags operands whose load has issued but not yet written back.
// Index ZR_IDX (XZR) has no real storage and always reads as zero.

// One read port: zero register, write bypass, then storage; busy masked by bypass.
module regfile_wb_rdport #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int ZR_IDX = 31,
    parameter int NREG   = 32
) (
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic [NREG-1:0][DATA_W-1:0]  regs,
    input  logic [NREG-1:0]              pend,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_busy
);
    logic is_zr;
    logic hit;

    assign is_zr = (rd_addr == ADDR_W'(ZR_IDX));
    assign hit   = wb_en && (wb_addr == rd_addr);

    // Read mux: XZR first so a discarded write to 31 can never be bypassed out.
    always_comb begin
        rd_data = regs[rd_addr];
        if (is_zr)
            rd_data = '0;
        else if (hit)
            rd_data = wb_data;
    end

    // The write-back landing this cycle satisfies the operand already.
    assign rd_busy = pend[rd_addr] && !hit;
endmodule

module regfile_wb #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int ZR_IDX = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              ra_busy,
    output logic              rb_busy,
    output logic [5:0]        pend_cnt
);
    localparam int NREG   = 1 << ADDR_W;
    localparam int NPORTS = 2;

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREG-1:0]             pend_q, pend_d;
    logic [5:0]                  pend_cnt_q, pend_cnt_d;

    logic wr_ok;
    logic set_ok;

    assign wr_ok  = wb_en    && (wb_addr   != ADDR_W'(ZR_IDX));
    assign set_ok = pend_set && (pend_addr != ADDR_W'(ZR_IDX));

    // Storage next-state; the XZR slot is pinned to zero so it folds away.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok)
            regs_d[wb_addr] = wb_data;
        regs_d[ZR_IDX] = '0;
    end

    // Scoreboard next-state: clear on write-back, then set so a back-to-back
    // load to the same destination stays pending.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok)
            pend_d[wb_addr] = 1'b0;
        if (set_ok)
            pend_d[pend_addr] = 1'b1;
        pend_d[ZR_IDX] = 1'b0;
    end

    // Pending count tracks the next-state vector so it lands on the same edge.
    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < NREG; i++)
            pend_cnt_d = pend_cnt_d + 6'(pend_d[i]);
    end

    // All state clears asynchronously; a write presented during reset is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q     <= '0;
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    logic [NPORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [NPORTS-1:0][DATA_W-1:0] rd_data;
    logic [NPORTS-1:0]             rd_busy;

    assign rd_addr = {rb_addr, ra_addr};

    genvar g;
    generate
        for (g = 0; g < NPORTS; g++) begin : g_rd
            regfile_wb_rdport #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .ZR_IDX (ZR_IDX),
                .NREG   (NREG)
            ) u_rd (
                .rd_addr (rd_addr[g]),
                .regs    (regs_q),
                .pend    (pend_q),
                .wb_en   (wb_en),
                .wb_addr (wb_addr),
                .wb_data (wb_data),
                .rd_data (rd_data[g]),
                .rd_busy (rd_busy[g])
            );
        end
    endgenerate

    assign ra_data = rd_data[0];
    assign rb_data = rd_data[1];
    assign ra_busy = rd_busy[0];
    assign rb_busy = rd_busy[1];
endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: a behavioural model predicts each sampled
// output set, pushes it into a queue, and a monitor pops and compares.
module tb_regfile_wb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic [4:0]  ra_addr = '0;
    logic [4:0]  rb_addr = '0;
    logic [63:0] ra_data, rb_data;
    logic        pend_set = 1'b0;
    logic [4:0]  pend_addr = '0;
    logic        ra_busy, rb_busy;
    logic [5:0]  pend_cnt;

    regfile_wb dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
        .pend_set(pend_set), .pend_addr(pend_addr), .ra_busy(ra_busy),
        .rb_busy(rb_busy), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] a, b;
        logic        ab, bb;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   errors = 0;
    int   checks = 0;
    int   sample_id = 0;

    // Reference model: architectural state as plain arrays.
    logic [63:0] mreg [32];
    bit          mpend[32];

    function automatic logic [63:0] m_read(input logic [4:0] a);
        if (a == 5'd31) return 64'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mreg[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        return mpend[a] && !(wb_en && wb_addr == a);
    endfunction

    function automatic logic [5:0] m_cnt();
        int n = 0;
        foreach (mpend[i]) n += int'(mpend[i]);
        return 6'(n);
    endfunction

    task automatic m_clear();
        foreach (mreg[i]) begin mreg[i] = '0; mpend[i] = 0; end
    endtask

    task automatic m_edge();
        if (wb_en && wb_addr != 5'd31) begin
            mreg[wb_addr]  = wb_data;
            mpend[wb_addr] = 0;
        end
        if (pend_set && pend_addr != 5'd31) mpend[pend_addr] = 1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.id = sample_id++;
        e.a = m_read(ra_addr);  e.b = m_read(rb_addr);
        e.ab = m_busy(ra_addr); e.bb = m_busy(rb_addr);
        e.cnt = m_cnt();
        q.push_back(e);
        -> chk_ev;
    endtask

    // One cycle: drive after negedge, sample before posedge, advance model at edge.
    task automatic step(input logic en, input logic [4:0] wa, input logic [63:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic ps, input logic [4:0] pa);
        logic rst_at_edge;
        @(negedge clk); #1;
        wb_en = en; wb_addr = wa; wb_data = wd;
        ra_addr = ra; rb_addr = rb; pend_set = ps; pend_addr = pa;
        #1 push_exp();
        rst_at_edge = rst;
        @(posedge clk); #1;
        if (!rst_at_edge) m_edge();
    endtask

    // Monitor: compare each presented sample with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            if (q.size() == 0) begin
                errors++; checks++;
                $display("FAIL empty_queue: monitor triggered with no expectation");
            end else begin
                e = q.pop_front();
                checks += 5;
                if (ra_data !== e.a) begin errors++;
                    $display("FAIL ra_data #%0d: got %h want %h", e.id, ra_data, e.a); end
                if (rb_data !== e.b) begin errors++;
                    $display("FAIL rb_data #%0d: got %h want %h", e.id, rb_data, e.b); end
                if (ra_busy !== e.ab) begin errors++;
                    $display("FAIL ra_busy #%0d: got %b want %b", e.id, ra_busy, e.ab); end
                if (rb_busy !== e.bb) begin errors++;
                    $display("FAIL rb_busy #%0d: got %b want %b", e.id, rb_busy, e.bb); end
                if (pend_cnt !== e.cnt) begin errors++;
                    $display("FAIL pend_cnt #%0d: got %0d want %0d", e.id, pend_cnt, e.cnt); end
            end
        end
    end

    initial begin
        logic [4:0] wa, ra, rb, pa;
        m_clear();

        // Reset state, including a discarded write to XZR while in reset.
        step(1, 5'd31, 64'hDEAD_BEEF_0000_0001, 5'd31, 5'd5, 0, 5'd0);
        rst = 1'b0;
        step(1, 5'd31, 64'hDEAD_BEEF_0000_0001, 5'd31, 5'd5, 0, 5'd0);
        step(0, 5'd0, 64'd0, 5'd31, 5'd5, 0, 5'd0);

        // Write then read, neighbour untouched.
        step(1, 5'd7, 64'h0123_4567_89AB_CDEF, 5'd8, 5'd0, 0, 5'd0);
        step(0, 5'd0, 64'd0, 5'd7, 5'd8, 0, 5'd0);

        // Same-cycle bypass on both ports.
        step(1, 5'd3, 64'hAAAA_0000_5555_FFFF, 5'd3, 5'd3, 0, 5'd0);
        step(0, 5'd0, 64'd0, 5'd3, 5'd7, 0, 5'd0);

        // Scoreboard lifecycle on X4.
        step(0, 5'd0, 64'd0, 5'd4, 5'd4, 1, 5'd4);
        step(0, 5'd0, 64'd0, 5'd4, 5'd5, 0, 5'd0);
        step(1, 5'd4, 64'h4444, 5'd4, 5'd4, 0, 5'd0);
        step(0, 5'd0, 64'd0, 5'd4, 5'd4, 0, 5'd0);

        // Simultaneous clear and set on X9: set wins, data still written.
        step(0, 5'd0, 64'd0, 5'd9, 5'd9, 1, 5'd9);
        step(1, 5'd9, 64'h9999_0000_9999, 5'd1, 5'd2, 1, 5'd9);
        step(0, 5'd0, 64'd0, 5'd9, 5'd9, 1, 5'd9);
        step(0, 5'd0, 64'd0, 5'd9, 5'd31, 1, 5'd31);
        step(1, 5'd9, 64'h1, 5'd9, 5'd9, 0, 5'd0);

        // Randomized traffic with bypass-biased read addresses.
        for (int i = 0; i < 400; i++) begin
            wa = 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            pa = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, ra, rb,
                 1'($urandom_range(0, 2) == 0), pa);
        end

        // Fill X0..X30 with their index, mark five pending.
        for (int i = 0; i < 31; i++)
            step(1, 5'(i), 64'(i), 5'(i), 5'(30 - i), 0, 5'd0);
        for (int i = 0; i < 5; i++)
            step(0, 5'd0, 64'd0, 5'(i * 4 + 1), 5'(i * 3), 1, 5'(i * 6 + 1));
        step(0, 5'd0, 64'd0, 5'd13, 5'd7, 0, 5'd0);

        // Async reset pulse between edges, no clock edge involved.
        @(negedge clk); #1;
        wb_en = 1'b0; pend_set = 1'b0; ra_addr = 5'd13; rb_addr = 5'd30;
        rst = 1'b1; #1;
        m_clear();
        push_exp();
        #1 wb_en = 1'b1; wb_addr = 5'd2; wb_data = 64'hB0B0_CAFE; ra_addr = 5'd2; rb_addr = 5'd6;
        #1 push_exp();
        #1 wb_en = 1'b0; rst = 1'b0;
        step(0, 5'd0, 64'd0, 5'd2, 5'd19, 0, 5'd0);
        step(1, 5'd19, 64'h19, 5'd19, 5'd1, 1, 5'd1);
        step(0, 5'd0, 64'd0, 5'd19, 5'd1, 0, 5'd0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
